// File: rtl/je_sched_pkg.sv
// Shared definitions for the JPEG frame sequencer: state encoding,
// status byte layout, the default watchdog limit and small helper functions.
package je_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_START_ENC = 3'd3,
    ST_ENCODE    = 3'd4,
    ST_READY     = 3'd5,
    ST_READOUT   = 3'd6,
    ST_ERR       = 3'd7
  } sched_state_e;

  localparam int STAT_ERR_BIT   = 7;
  localparam int STAT_READY_BIT = 6;
  localparam int STAT_BUSY_BIT  = 5;

  localparam int unsigned DEF_TO_CYC = 32'h00FF_FFFF;

  // Status byte seen by the host for a given state.
  function automatic logic [7:0] make_status(input sched_state_e s);
    logic [7:0] st;
    st = '0;
    st[2:0]            = s;
    st[STAT_ERR_BIT]   = (s == ST_ERR);
    st[STAT_READY_BIT] = (s == ST_READY);
    st[STAT_BUSY_BIT]  = (s != ST_IDLE) && (s != ST_ERR);
    return st;
  endfunction

  // States that wait on an external block and are guarded by the watchdog.
  function automatic logic wdog_guarded(input sched_state_e s);
    return (s == ST_ARM) || (s == ST_CAPTURE) || (s == ST_ENCODE);
  endfunction

endpackage

// File: rtl/je_sched_wdog.sv
// Watchdog for the frame sequencer: clears on request, counts while enabled
// and flags expiry on the cycle the count sits at TO_CYC-1.
module je_sched_wdog
  import je_sched_pkg::*;
#(
  parameter int          TO_W   = 24,
  parameter int unsigned TO_CYC = DEF_TO_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Clear wins over counting; the count holds at the limit since the FSM leaves anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/je_frame_sched.sv
// Frame sequencer for the JPEG capture path: snapshot -> arm on vsync ->
// capture -> encode -> hold -> SPI readout, with watchdog, abort and status.
// Optional macro JE_SCHED_CONTINUOUS_EN re-arms on the next frame after
// each readout instead of returning to idle.
module je_frame_sched
  import je_sched_pkg::*;
#(
  parameter int          ASZ    = 17,
  parameter int          TO_W   = 24,
  parameter int unsigned TO_CYC = DEF_TO_CYC,
  parameter int          CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_snap,
  input  logic             host_rd_start,
  input  logic             host_abort,
  input  logic             cam_vsync,
  input  logic             cap_done,
  input  logic             je_done,
  input  logic [ASZ-1:0]   jpeg_size,
  input  logic             rd_done,
  output logic             cap_en,
  output logic             je_start,
  output logic             rd_en,
  output logic [ASZ-1:0]   jpeg_size_q,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       status
);

  sched_state_e     state_q, state_d;
  logic             vsync_q;
  logic             cap_en_q, cap_en_d;
  logic             je_start_q, je_start_d;
  logic             rd_en_q, rd_en_d;
  logic [ASZ-1:0]   jpeg_size_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       status_q, status_d;
  logic             vsync_rise;
  logic             wd_expire;

  assign vsync_rise = cam_vsync & ~vsync_q;

  je_sched_wdog #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .enable (wdog_guarded(state_q)),
    .expire (wd_expire)
  );

  // Next state and next output values; abort beats exit events, which beat the watchdog.
  always_comb begin
    state_d     = state_q;
    jpeg_size_d = jpeg_size_q;
    frame_cnt_d = frame_cnt_q;
    if (host_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (host_snap) state_d = ST_ARM;
        ST_ARM: begin
          if (vsync_rise)     state_d = ST_CAPTURE;
          else if (wd_expire) state_d = ST_ERR;
        end
        ST_CAPTURE: begin
          if (cap_done)       state_d = ST_START_ENC;
          else if (wd_expire) state_d = ST_ERR;
        end
        ST_START_ENC: state_d = ST_ENCODE;
        ST_ENCODE: begin
          if (je_done) begin
            state_d     = ST_READY;
            jpeg_size_d = jpeg_size;
          end else if (wd_expire) begin
            state_d = ST_ERR;
          end
        end
        ST_READY:     if (host_rd_start) state_d = ST_READOUT;
        ST_READOUT: begin
          if (rd_done) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef JE_SCHED_CONTINUOUS_EN
            state_d = ST_ARM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
        ST_ERR:       state_d = ST_ERR;
        default:      state_d = ST_IDLE;
      endcase
    end
    cap_en_d   = (state_d == ST_CAPTURE);
    je_start_d = (state_d == ST_START_ENC);
    rd_en_d    = (state_d == ST_READOUT);
    status_d   = make_status(state_d);
  end

  // State, vsync history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      cap_en_q    <= 1'b0;
      je_start_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      jpeg_size_q <= '0;
      frame_cnt_q <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= cam_vsync;
      cap_en_q    <= cap_en_d;
      je_start_q  <= je_start_d;
      rd_en_q     <= rd_en_d;
      jpeg_size_q <= jpeg_size_d;
      frame_cnt_q <= frame_cnt_d;
      status_q    <= status_d;
    end
  end

  assign cap_en    = cap_en_q;
  assign je_start  = je_start_q;
  assign rd_en     = rd_en_q;
  assign frame_cnt = frame_cnt_q;
  assign status    = status_q;

endmodule

// File: tb/tb_je_frame_sched.sv
// Self-checking bench for je_frame_sched. Two instances share the stimulus:
// dut_a with the default watchdog limit and dut_b with a 16-cycle limit.
// A behavioural model tracks both; directed sequences add constant checks.
module tb_je_frame_sched;

  localparam int S_IDLE = 0, S_ARM = 1, S_CAPTURE = 2, S_START_ENC = 3;
  localparam int S_ENCODE = 4, S_READY = 5, S_READOUT = 6, S_ERR = 7;
`ifdef JE_SCHED_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_snap = 1'b0, host_rd_start = 1'b0, host_abort = 1'b0;
  logic        cam_vsync = 1'b0, cap_done = 1'b0, je_done = 1'b0, rd_done = 1'b0;
  logic [16:0] jpeg_size = '0;

  logic        a_cap_en, a_je_start, a_rd_en, b_cap_en, b_je_start, b_rd_en;
  logic [16:0] a_jpeg_size_q, b_jpeg_size_q;
  logic [7:0]  a_frame_cnt, b_frame_cnt, a_status, b_status;

  int checkCount = 0;
  int failCount  = 0;
  int cycNum     = 0;

  always #5 clk = ~clk;

  je_frame_sched dut_a (
    .clk(clk), .reset(reset), .host_snap(host_snap), .host_rd_start(host_rd_start),
    .host_abort(host_abort), .cam_vsync(cam_vsync), .cap_done(cap_done),
    .je_done(je_done), .jpeg_size(jpeg_size), .rd_done(rd_done),
    .cap_en(a_cap_en), .je_start(a_je_start), .rd_en(a_rd_en),
    .jpeg_size_q(a_jpeg_size_q), .frame_cnt(a_frame_cnt), .status(a_status)
  );

  je_frame_sched #(.TO_CYC(16)) dut_b (
    .clk(clk), .reset(reset), .host_snap(host_snap), .host_rd_start(host_rd_start),
    .host_abort(host_abort), .cam_vsync(cam_vsync), .cap_done(cap_done),
    .je_done(je_done), .jpeg_size(jpeg_size), .rd_done(rd_done),
    .cap_en(b_cap_en), .je_start(b_je_start), .rd_en(b_rd_en),
    .jpeg_size_q(b_jpeg_size_q), .frame_cnt(b_frame_cnt), .status(b_status)
  );

  // Reference model: current state, cycles spent in it, previous vsync,
  // latched size and completed-readout count.
  typedef struct {
    int         st;
    int         age;
    bit         pv;
    logic [16:0] sz;
    logic [7:0]  cnt;
  } mdl_t;

  mdl_t m[2];
  int   lim[2];

  function automatic logic [7:0] expStatus(input int st);
    logic [7:0] s;
    s = 8'h00;
    s[7] = (st == S_ERR);
    s[6] = (st == S_READY);
    s[5] = (st != S_IDLE) && (st != S_ERR);
    s[2:0] = 3'(st);
    return s;
  endfunction

  // One clock of the reference model for instance k, using the inputs just sampled.
  task automatic modelStep(input int k);
    int nst;
    bit tmo;
    nst = m[k].st;
    tmo = (m[k].st == S_ARM || m[k].st == S_CAPTURE || m[k].st == S_ENCODE)
          && (m[k].age >= lim[k]);
    if (reset) begin
      m[k].st = S_IDLE; m[k].age = 1; m[k].pv = 1'b0; m[k].sz = '0; m[k].cnt = '0;
    end else begin
      if (host_abort) nst = S_IDLE;
      else begin
        case (m[k].st)
          S_IDLE:      if (host_snap) nst = S_ARM;
          S_ARM:       if (cam_vsync && !m[k].pv) nst = S_CAPTURE; else if (tmo) nst = S_ERR;
          S_CAPTURE:   if (cap_done) nst = S_START_ENC; else if (tmo) nst = S_ERR;
          S_START_ENC: nst = S_ENCODE;
          S_ENCODE: begin
            if (je_done) begin nst = S_READY; m[k].sz = jpeg_size; end
            else if (tmo) nst = S_ERR;
          end
          S_READY:     if (host_rd_start) nst = S_READOUT;
          S_READOUT: begin
            if (rd_done) begin
              nst = CONT ? S_ARM : S_IDLE;
              m[k].cnt = m[k].cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
      m[k].age = (nst != m[k].st) ? 1 : m[k].age + 1;
      m[k].st  = nst;
      m[k].pv  = cam_vsync;
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic checkOutput();
    logic [35:0] act, exp;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) act = {a_cap_en, a_je_start, a_rd_en, a_jpeg_size_q, a_frame_cnt, a_status};
      else        act = {b_cap_en, b_je_start, b_rd_en, b_jpeg_size_q, b_frame_cnt, b_status};
      exp = {(m[k].st == S_CAPTURE), (m[k].st == S_START_ENC), (m[k].st == S_READOUT),
             m[k].sz, m[k].cnt, expStatus(m[k].st)};
      checkCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL model_outputs dut%0d cyc=%0d actual=%h required=%h", k, cycNum, act, exp);
      end
    end
  endtask

  task automatic checkConst(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cycNum, act, exp);
    end
  endtask

  // Drive one cycle of pulses (vsync and reset are levels set by the caller).
  task automatic applyStimulus(input bit snap, input bit rds, input bit abt,
                               input bit cap, input bit jed, input logic [16:0] sz,
                               input bit rdd);
    host_snap = snap; host_rd_start = rds; host_abort = abt;
    cap_done = cap; je_done = jed; jpeg_size = sz; rd_done = rdd;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    cycNum++;
    checkOutput();
    host_snap = 0; host_rd_start = 0; host_abort = 0;
    cap_done = 0; je_done = 0; rd_done = 0;
  endtask

  task automatic step();
    applyStimulus(0, 0, 0, 0, 0, '0, 0);
  endtask

  // Short complete frame used for the counter wrap and readout-abort cases.
  task automatic quickFrame(input logic [16:0] sz, input bit finish);
    cam_vsync = 0; applyStimulus(1, 0, 0, 0, 0, '0, 0);
    cam_vsync = 1; step();
    applyStimulus(0, 0, 0, 1, 0, '0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 1, sz, 0);
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    if (finish) applyStimulus(0, 0, 0, 0, 0, '0, 1);
  endtask

  typedef struct {
    bit snap, rds, abt, vs, cap, jed, rdd;
    logic [16:0] sz;
    int reps;
    logic [7:0] expSt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int capHigh, jeHigh;
    logic [7:0] cnt0;
    logic [7:0] endSt;
    lim[0] = 32'h00FF_FFFF;
    lim[1] = 16;
    endSt = CONT ? 8'h21 : 8'h00;

    // Reset state
    reset = 1; step(); step();
    checkConst("reset_status", 32'(a_status), 32'h00);
    checkConst("reset_outputs", {a_cap_en, a_je_start, a_rd_en, a_frame_cnt}, 32'h0);
    reset = 0; step();

    // Nominal frame as a vector table (expected status refers to dut_a)
    tbl.push_back('{1,0,0,0,0,0,0,17'h0,    1, 8'h21});
    tbl.push_back('{0,0,0,0,0,0,0,17'h0,    4, 8'h21});
    tbl.push_back('{0,0,0,1,0,0,0,17'h0,    1, 8'h22});
    tbl.push_back('{0,0,0,1,0,0,0,17'h0,   99, 8'h22});
    tbl.push_back('{0,0,0,0,1,0,0,17'h0,    1, 8'h23});
    tbl.push_back('{0,0,0,0,0,0,0,17'h0,    4, 8'h24});
    tbl.push_back('{0,0,0,0,0,1,0,17'h01234,1, 8'h65});
    tbl.push_back('{0,0,0,0,0,0,0,17'h0,    2, 8'h65});
    tbl.push_back('{0,1,0,0,0,0,0,17'h0,    1, 8'h26});
    tbl.push_back('{0,0,0,0,0,0,0,17'h0,    2, 8'h26});
    tbl.push_back('{0,0,0,0,0,0,1,17'h0,    1, endSt});
    capHigh = 0; jeHigh = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        cam_vsync = tbl[i].vs;
        applyStimulus(tbl[i].snap, tbl[i].rds, tbl[i].abt, tbl[i].cap,
                      tbl[i].jed, tbl[i].sz, tbl[i].rdd);
        if (a_cap_en) capHigh++;
        if (a_je_start) jeHigh++;
        checkConst("nominal_status", 32'(a_status), 32'(tbl[i].expSt));
      end
    end
    checkConst("nominal_cap_en_cycles", 32'(capHigh), 32'd100);
    checkConst("nominal_je_start_cycles", 32'(jeHigh), 32'd1);
    checkConst("nominal_jpeg_size_q", 32'(a_jpeg_size_q), 32'h01234);
    checkConst("nominal_frame_cnt", 32'(a_frame_cnt), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);
    checkConst("abort_clears_err", 32'(b_status), 32'h00);

    // Watchdog expiry in CAPTURE on the 16-cycle instance
    cam_vsync = 0; applyStimulus(1, 0, 0, 0, 0, '0, 0);
    cam_vsync = 1; step();
    for (int i = 0; i < 15; i++) step();
    checkConst("wdog_before_expiry", 32'(b_status), 32'h22);
    step();
    checkConst("wdog_err_status", 32'(b_status), 32'h87);
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    checkConst("err_ignores_snap", 32'(b_status), 32'h87);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);
    checkConst("err_abort_status", 32'(b_status), 32'h00);

    // je_done on the same cycle as watchdog expiry in ENCODE
    cam_vsync = 0; applyStimulus(1, 0, 0, 0, 0, '0, 0);
    cam_vsync = 1; step();
    for (int i = 0; i < 3; i++) step();
    applyStimulus(0, 0, 0, 1, 0, '0, 0);
    step();
    for (int i = 0; i < 15; i++) step();
    checkConst("encode_before_expiry", 32'(b_status), 32'h24);
    applyStimulus(0, 0, 0, 0, 1, 17'h1ABCD, 0);
    checkConst("exit_beats_wdog_status", 32'(b_status), 32'h65);
    checkConst("exit_beats_wdog_size", 32'(b_jpeg_size_q), 32'h1ABCD);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);

    // Vsync already high on entering ARM needs a fresh edge
    cam_vsync = 1; step(); step();
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step();
    checkConst("vsync_high_no_capture", 32'(a_status), 32'h21);
    cam_vsync = 0; step(); step();
    checkConst("vsync_low_still_arm", 32'(a_status), 32'h21);
    cam_vsync = 1; step();
    checkConst("vsync_fresh_edge", 32'(a_status), 32'h22);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);

    // Abort during READOUT
    quickFrame(17'h00055, 1'b0);
    checkConst("readout_rd_en", 32'(a_rd_en), 32'd1);
    cnt0 = m[0].cnt;
    applyStimulus(0, 0, 1, 0, 0, '0, 0);
    checkConst("abort_rd_en_low", 32'(a_rd_en), 32'd0);
    checkConst("abort_keeps_cnt", 32'(a_frame_cnt), 32'(cnt0));
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    checkConst("stray_rd_done_status", 32'(a_status), 32'h00);
    checkConst("stray_rd_done_cnt", 32'(a_frame_cnt), 32'(cnt0));

    // 256 frames from reset: counter wraps to zero
    reset = 1; step(); step(); reset = 0;
    for (int f = 0; f < 256; f++) begin
      quickFrame(17'(f), 1'b1);
      checkConst("post_readout_state", 32'(a_status[2:0]), CONT ? 32'd1 : 32'd0);
      if (f == 254) checkConst("frame_cnt_ff", 32'(a_frame_cnt), 32'hFF);
    end
    checkConst("frame_cnt_wrap", 32'(a_frame_cnt), 32'h00);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) cam_vsync = ~cam_vsync;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0, 17'($urandom), $urandom_range(0, 3) == 0);
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
